// File: rtl/gt_pack_telemetry.sv
// Transmit-side framer for the GT telemetry link: serialises 88-bit packets into
// SOF + 3 payload words with K-character framing, idling with comma words between frames.
module gt_pack_telemetry #(
    parameter int unsigned IDLE_EVERY = 8,
    parameter logic [31:0] IDLE_WORD  = 32'h50BC_50BC,
    parameter logic [3:0]  IDLE_K     = 4'b0101
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [87:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] gt_data,
    output logic [3:0]  gt_data_is_k,
    output logic [31:0] frame_count,
    output logic        sending
);

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        P0,
        P1,
        P2
    } state_t;

    localparam logic [7:0] SOF_K_CHAR = 8'hFB;
    localparam logic [3:0] SOF_K      = 4'b0001;
    localparam logic [7:0] GAP_LIMIT  = 8'(IDLE_EVERY);

    state_t      state;
    state_t      next_state;
    logic [87:0] capture;
    logic [7:0]  seq;
    logic [7:0]  gap_cnt;
    logic [31:0] next_data;
    logic [3:0]  next_k;
    logic        accept;

    function automatic logic [7:0] byte_xor(input logic [87:0] pkt);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 11; i++) begin
            acc = acc ^ pkt[8*i +: 8];
        end
        return acc;
    endfunction

    // Refusing the packet in P2 once the run limit is reached is what forces the idle word.
    assign in_ready = !rst && ((state == IDLE) || ((state == P2) && (gap_cnt < GAP_LIMIT)));
    assign accept   = in_valid && in_ready;

    // The output word is chosen from the state being entered, so gt_data lines up with state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        next_state = state;
        next_data  = IDLE_WORD;
        next_k     = IDLE_K;

        case (state)
            IDLE:    next_state = accept ? SOF : IDLE;
            SOF:     next_state = P0;
            P0:      next_state = P1;
            P1:      next_state = P2;
            P2:      next_state = accept ? SOF : IDLE;
            default: next_state = IDLE;
        endcase

        case (next_state)
            SOF: begin
                next_data = {seq, 8'h00, 8'h00, SOF_K_CHAR};
                next_k    = SOF_K;
            end
            P0: begin
                next_data = capture[31:0];
                next_k    = 4'b0000;
            end
            P1: begin
                next_data = capture[63:32];
                next_k    = 4'b0000;
            end
            P2: begin
                next_data = {byte_xor(capture), capture[87:64]};
                next_k    = 4'b0000;
            end
            default: begin
                next_data = IDLE_WORD;
                next_k    = IDLE_K;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            gt_data      <= IDLE_WORD;
            gt_data_is_k <= IDLE_K;
            seq          <= 8'h00;
            gap_cnt      <= 8'h00;
            frame_count  <= 32'h0000_0000;
            sending      <= 1'b0;
            capture      <= 88'h0;
        end else begin
            state        <= next_state;
            gt_data      <= next_data;
            gt_data_is_k <= next_k;
            sending      <= (next_state != IDLE);

            if (accept) begin
                capture <= in_data;
            end

            if (next_state == SOF) begin
                seq         <= seq + 8'h01;
                frame_count <= frame_count + 32'h0000_0001;
                if (gap_cnt != 8'hFF) begin
                    gap_cnt <= gap_cnt + 8'h01;
                end
            end else if (next_state == IDLE) begin
                gap_cnt <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_gt_pack_telemetry.sv
// Directed bench for gt_pack_telemetry built with IDLE_EVERY = 4 so forced idles
// show up quickly; expected words are hand-computed from the frame format.
module tb_gt_pack_telemetry;

    localparam logic [31:0] IDLE_WORD = 32'h50BC_50BC;
    localparam logic [3:0]  IDLE_K    = 4'b0101;

    logic        clk = 1'b0;
    logic        rst;
    logic [87:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] gt_data;
    logic [3:0]  gt_data_is_k;
    logic [31:0] frame_count;
    logic        sending;

    int total = 0;
    int bad   = 0;

    gt_pack_telemetry #(
        .IDLE_EVERY (4),
        .IDLE_WORD  (IDLE_WORD),
        .IDLE_K     (IDLE_K)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .gt_data      (gt_data),
        .gt_data_is_k (gt_data_is_k),
        .frame_count  (frame_count),
        .sending      (sending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic s);
        check({tag, "_data"}, 96'(gt_data), 96'(d));
        check({tag, "_k"}, 96'(gt_data_is_k), 96'(k));
        check({tag, "_sending"}, 96'(sending), 96'(s));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [7:0] model_csum(input logic [87:0] p);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < 11; i++) acc = acc ^ p[8*i +: 8];
        return acc;
    endfunction

    function automatic logic [31:0] sof_word(input logic [7:0] s);
        return {s, 16'h0000, 8'hFB};
    endfunction

    initial begin
        int n_sof;
        int sent;
        logic [87:0] pkt;

        // Reset state and idle stream.
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 88'h0;
        repeat (2) step();
        check("rst_ready", 96'(in_ready), 96'(0));
        check("rst_fc", 96'(frame_count), 96'(0));
        chk_word("rst_word", IDLE_WORD, IDLE_K, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready", 96'(in_ready), 96'(1));
        repeat (3) begin
            step();
            chk_word("idle_word", IDLE_WORD, IDLE_K, 1'b0);
        end

        // Single frame of all-0x01 bytes; odd byte count gives csum 0x01.
        in_data  = {11{8'h01}};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        sent = 0;
        chk_word("t2_sof", 32'h0000_00FB, 4'b0001, 1'b1);
        sent += int'(sending);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_word("t2_pay", 32'h0101_0101, 4'b0000, 1'b1);
            sent += int'(sending);
        end
        step();
        chk_word("t2_idle", IDLE_WORD, IDLE_K, 1'b0);
        sent += int'(sending);
        check("t2_sent_cycles", 96'(sent), 96'(4));
        check("t2_fc", 96'(frame_count), 96'(1));

        // Back-to-back frames with in_valid held: idle forced after 4 frames.
        do_reset();
        pkt      = 88'h0B_0A_09_08_07_06_05_04_03_02_01;
        in_data  = pkt;
        in_valid = 1'b1;
        step();
        for (int k = 0; k < 18; k++) begin
            if (k == 16) begin
                chk_word("t3_idle", IDLE_WORD, IDLE_K, 1'b0);
                check("t3_ready_idle", 96'(in_ready), 96'(1));
            end else if (k == 17) begin
                chk_word("t3_sof4", sof_word(8'd4), 4'b0001, 1'b1);
                check("t3_ready_sof4", 96'(in_ready), 96'(0));
            end else begin
                case (k % 4)
                    0: chk_word("t3_sof", sof_word(8'(k / 4)), 4'b0001, 1'b1);
                    1: chk_word("t3_p0", pkt[31:0], 4'b0000, 1'b1);
                    2: chk_word("t3_p1", pkt[63:32], 4'b0000, 1'b1);
                    default: chk_word("t3_p2", {model_csum(pkt), pkt[87:64]}, 4'b0000, 1'b1);
                endcase
                check("t3_ready", 96'(in_ready), 96'((k % 4 == 3) && (k / 4 < 3)));
            end
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        chk_word("t3_end_idle", IDLE_WORD, IDLE_K, 1'b0);
        check("t3_fc", 96'(frame_count), 96'(5));

        // Capture isolation; bytes 00..AA XOR to 0xBB.
        do_reset();
        in_data  = 88'h00_11_22_33_44_55_66_77_88_99_AA;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = {11{8'hFF}};
        chk_word("t4_sof", 32'h0000_00FB, 4'b0001, 1'b1);
        step();
        chk_word("t4_p0", 32'h7788_99AA, 4'b0000, 1'b1);
        in_data = {11{8'h5A}};
        step();
        chk_word("t4_p1", 32'h3344_5566, 4'b0000, 1'b1);
        step();
        chk_word("t4_p2", 32'hBB00_1122, 4'b0000, 1'b1);

        // 257 frames: sequence number wraps on the 257th SOF.
        do_reset();
        in_data  = {11{8'hC3}};
        in_valid = 1'b1;
        n_sof    = 0;
        for (int c = 0; c < 1500 && n_sof < 257; c++) begin
            step();
            if (gt_data_is_k == 4'b0001) begin
                check("t5_seq", 96'(gt_data[31:24]), 96'(n_sof[7:0]));
                n_sof++;
                if (n_sof == 257) in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("t5_sof_total", 96'(n_sof), 96'(257));
        check("t5_fc", 96'(frame_count), 96'(257));
        repeat (4) step();

        // Asynchronous reset during P1 drops the frame.
        do_reset();
        in_data  = {11{8'h3C}};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk_word("t6_p1", 32'h3C3C_3C3C, 4'b0000, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk_word("t6_async", IDLE_WORD, IDLE_K, 1'b0);
        check("t6_ready_rst", 96'(in_ready), 96'(0));
        check("t6_fc_rst", 96'(frame_count), 96'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        in_data  = {11{8'h77}};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk_word("t6_sof", 32'h0000_00FB, 4'b0001, 1'b1);
        check("t6_fc", 96'(frame_count), 96'(1));
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
